// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier: FSM states,
// Booth recode operations and the recode decoder.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_e;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_e;

    // Pair is {B_lsb, q(-1)}: 01 -> add A, 10 -> subtract A, else nothing.
    function automatic booth_op_e booth_decode(input logic [1:0] pair);
        booth_op_e op;
        case (pair)
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/seq_booth_mult_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of A into the
// accumulator, then arithmetic right shift of {acc, B, q(-1)}.
module booth_step
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH+1:0] i_acc,
    input  logic [WIDTH:0]   i_a,
    input  logic [WIDTH:0]   i_b,
    input  logic [1:0]       i_pair,
    output logic [WIDTH+1:0] o_acc,
    output logic [WIDTH:0]   o_b,
    output logic             o_q
);

    booth_op_e        w_op;
    logic [WIDTH+1:0] w_a_ext;
    logic [WIDTH+1:0] w_sum;

    assign w_op    = booth_decode(i_pair);
    assign w_a_ext = {i_a[WIDTH], i_a};

    always_comb begin
        w_sum = i_acc;
        case (w_op)
            BOOTH_ADD: w_sum = i_acc + w_a_ext;
            BOOTH_SUB: w_sum = i_acc - w_a_ext;
            default:   w_sum = i_acc;
        endcase
    end

    // The accumulator's lsb shifts into B; B's lsb becomes the new q(-1).
    assign o_acc = {w_sum[WIDTH+1], w_sum[WIDTH+1:1]};
    assign o_b   = {w_sum[0], i_b[WIDTH:1]};
    assign o_q   = i_b[0];

endmodule

// File: rtl/seq_booth_mult.sv
// Sequential radix-2 Booth multiplier with signed/unsigned mode, valid/ready
// on both sides, synchronous flush and a busy flag. One multiply in flight.
module seq_booth_mult
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               src_valid,
    output logic               src_ready,
    input  logic               mode_signed,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic               flush,
    output logic               dst_valid,
    input  logic               dst_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output mult_state_e        dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 2);

    mult_state_e        r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH+1:0]   r_acc;
    logic [WIDTH:0]     r_a;
    logic [WIDTH:0]     r_b;
    logic               r_q;
    logic [2*WIDTH-1:0] r_product;
    logic               r_dst_valid;
    logic               r_busy;
    logic               r_src_ready;

    logic [WIDTH+1:0]   w_acc_n;
    logic [WIDTH:0]     w_b_n;
    logic               w_q_n;
    logic [2*WIDTH-1:0] w_prod_n;
    logic [WIDTH:0]     w_a_load;
    logic [WIDTH:0]     w_b_load;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .i_acc  (r_acc),
        .i_a    (r_a),
        .i_b    (r_b),
        .i_pair ({r_b[0], r_q}),
        .o_acc  (w_acc_n),
        .o_b    (w_b_n),
        .o_q    (w_q_n)
    );

    // Low 2*WIDTH bits of {acc, B}: B supplies WIDTH+1 bits, acc the rest.
    assign w_prod_n = {w_acc_n[WIDTH-2:0], w_b_n};

    assign w_a_load = {mode_signed & multiplicand[WIDTH-1], multiplicand};
    assign w_b_load = {mode_signed & multiplier[WIDTH-1], multiplier};

    // Handshake: a transfer happens on any rising edge where valid and ready
    // are both high; src_ready is high only in IDLE, dst_valid only in DONE,
    // and product/dst_valid stay frozen until dst_ready completes the transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_q         <= 1'b0;
            r_product   <= '0;
            r_dst_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_src_ready <= 1'b1;
        end else if (flush) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_q         <= 1'b0;
            r_dst_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_src_ready <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (src_valid && r_src_ready) begin
                        r_a         <= w_a_load;
                        r_b         <= w_b_load;
                        r_acc       <= '0;
                        r_q         <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= CALC;
                        r_busy      <= 1'b1;
                        r_src_ready <= 1'b0;
                    end
                end
                CALC: begin
                    r_acc <= w_acc_n;
                    r_b   <= w_b_n;
                    r_q   <= w_q_n;
                    r_cnt <= r_cnt + CNT_W'(1);
                    // WIDTH+1 iterations: the last one runs with r_cnt == WIDTH.
                    if (r_cnt == CNT_W'(WIDTH)) begin
                        r_state     <= DONE;
                        r_dst_valid <= 1'b1;
                        r_product   <= w_prod_n;
                    end
                end
                DONE: begin
                    if (dst_ready) begin
                        r_state     <= IDLE;
                        r_dst_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_src_ready <= 1'b1;
                        r_cnt       <= '0;
                        r_acc       <= '0;
                        r_a         <= '0;
                        r_b         <= '0;
                        r_q         <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_dst_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_src_ready <= 1'b1;
                end
            endcase
        end
    end

    assign src_ready = r_src_ready;
    assign dst_valid = r_dst_valid;
    assign product   = r_product;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule
